game_mode_fsm: RTL and testbench

Parametrised top-level game-mode controller for the rhythm game, successor to the fixed six-mode state machine. Sequences IDLE → EDIT → DIFF → RUN ⇄ PAUSE → FINISH from debounced button pulses. Adds selectable difficulty, a lives counter that ends the game on misses, a pause timeout that auto-quits, and a win/lose flag. Sits between the button edge detectors and the display/song-playback blocks.

---
 rtl/game_pkg.sv | 16 +
 rtl/pause_timer.sv | 28 ++
 rtl/game_mode_fsm.sv | 121 ++++++++++++
 tb/tb_game_mode_fsm.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types for the rhythm-game mode controller.
package game_pkg;

    localparam int MODE_W  = 3;
    localparam int LIVES_W = 4;

    typedef enum logic [MODE_W-1:0] {
        M_IDLE   = 3'd1,
        M_EDIT   = 3'd2,
        M_DIFF   = 3'd3,
        M_RUN    = 3'd4,
        M_PAUSE  = 3'd5,
        M_FINISH = 3'd6
    } mode_t;

endpackage

// File: rtl/pause_timer.sv
// Counts cycles spent in PAUSE and flags the auto-quit point.
module pause_timer #(
    parameter int PAUSE_TIMEOUT = 12_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CNT_W = (PAUSE_TIMEOUT > 2) ? $clog2(PAUSE_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CNT_W'(1);
    end

    assign timeout = en && (cnt == LAST);

endmodule

// File: rtl/game_mode_fsm.sv
// Game-mode controller: mode sequencing, difficulty, lives, pause timeout.
module game_mode_fsm
    import game_pkg::*;
#(
    parameter int NUM_LEVELS    = 3,
    parameter int DEFAULT_LEVEL = 0,
    parameter int MAX_LIVES     = 5,
    parameter int PAUSE_TIMEOUT = 12_000_000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          btn_next,
    input  logic                          btn_alt,
    input  logic                          btn_up,
    input  logic                          btn_down,
    input  logic                          miss,
    input  logic                          fin_check,
    output logic [MODE_W-1:0]             mode,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [LIVES_W-1:0]            lives,
    output logic                          game_won,
    output logic                          run_en
);

    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam logic [LVL_W-1:0]   TOP_LVL  = LVL_W'(NUM_LEVELS - 1);
    localparam logic [LVL_W-1:0]   INIT_LVL = LVL_W'(DEFAULT_LEVEL);
    localparam logic [LIVES_W-1:0] FULL     = LIVES_W'(MAX_LIVES);

    mode_t              state, state_n;
    logic [LVL_W-1:0]   level_q, level_n;
    logic [LIVES_W-1:0] lives_q, lives_n;
    logic               won_q, won_n;
    logic               in_pause;
    logic               timeout;

    assign in_pause = (state == M_PAUSE);

    pause_timer #(
        .PAUSE_TIMEOUT(PAUSE_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (!in_pause),
        .en     (in_pause),
        .timeout(timeout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= M_IDLE;
            level_q <= INIT_LVL;
            lives_q <= FULL;
            won_q   <= 1'b0;
        end else begin
            state   <= state_n;
            level_q <= level_n;
            lives_q <= lives_n;
            won_q   <= won_n;
        end
    end

    always_comb begin
        state_n = state;
        level_n = level_q;
        lives_n = lives_q;
        won_n   = won_q;
        case (state)
            M_IDLE:
                if (btn_next) state_n = M_EDIT;
            M_EDIT:
                if (btn_next) state_n = M_DIFF;
            M_DIFF: begin
                if (btn_up && !btn_down && level_q != TOP_LVL)
                    level_n = level_q + LVL_W'(1);
                else if (btn_down && !btn_up && level_q != '0)
                    level_n = level_q - LVL_W'(1);
                if (btn_next) begin
                    state_n = M_RUN;
                    lives_n = FULL;
                    won_n   = 1'b0;
                end
            end
            M_RUN: begin
                if (fin_check) begin
                    state_n = M_FINISH;
                    won_n   = 1'b1;
                end else if (miss && lives_q <= LIVES_W'(1)) begin
                    state_n = M_FINISH;
                    lives_n = '0;
                    won_n   = 1'b0;
                end else begin
                    // a non-fatal miss still counts when pausing in the same cycle
                    if (miss) lives_n = lives_q - LIVES_W'(1);
                    if (btn_next) state_n = M_PAUSE;
                end
            end
            M_PAUSE: begin
                if (btn_alt || (!btn_next && timeout)) begin
                    state_n = M_FINISH;
                    won_n   = 1'b0;
                end else if (btn_next) begin
                    state_n = M_RUN;
                end
            end
            M_FINISH:
                if (btn_next) state_n = M_IDLE;
            default:
                state_n = M_IDLE;
        endcase
    end

    always_comb begin
        mode     = state;
        run_en   = (state == M_RUN);
        level    = level_q;
        lives    = lives_q;
        game_won = won_q;
    end

endmodule

// File: tb/tb_game_mode_fsm.sv
// Directed scenarios plus randomized run against a behavioural model.
module tb_game_mode_fsm;

    localparam int NL = 3;
    localparam int ML = 2;
    localparam int PT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_next = 1'b0, btn_alt = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       miss = 1'b0, fin_check = 1'b0;
    logic [2:0] mode;
    logic [1:0] level;
    logic [3:0] lives;
    logic       game_won, run_en;

    int checks = 0;
    int errors = 0;

    // reference model state, in plain integers
    int m_mode, m_level, m_lives, m_won, m_paused;

    game_mode_fsm #(
        .NUM_LEVELS(NL),
        .DEFAULT_LEVEL(0),
        .MAX_LIVES(ML),
        .PAUSE_TIMEOUT(PT)
    ) dut (
        .clk(clk), .rst(rst),
        .btn_next(btn_next), .btn_alt(btn_alt),
        .btn_up(btn_up), .btn_down(btn_down),
        .miss(miss), .fin_check(fin_check),
        .mode(mode), .level(level), .lives(lives),
        .game_won(game_won), .run_en(run_en)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode = 1; m_level = 0; m_lives = ML; m_won = 0; m_paused = 0;
    endtask

    task automatic model_step(input bit n, input bit a, input bit u,
                              input bit d, input bit mi, input bit f);
        int prev;
        prev = m_mode;
        case (m_mode)
            1: if (n) m_mode = 2;
            2: if (n) m_mode = 3;
            3: begin
                if (u && !d) m_level = (m_level + 1 > NL - 1) ? NL - 1 : m_level + 1;
                if (d && !u) m_level = (m_level == 0) ? 0 : m_level - 1;
                if (n) begin m_mode = 4; m_lives = ML; m_won = 0; end
            end
            4: begin
                if (f) begin m_mode = 6; m_won = 1; end
                else if (mi && m_lives == 1) begin m_lives = 0; m_mode = 6; m_won = 0; end
                else begin
                    if (mi) m_lives = m_lives - 1;
                    if (n) m_mode = 5;
                end
            end
            5: begin
                if (a) begin m_mode = 6; m_won = 0; end
                else if (n) m_mode = 4;
                else if (m_paused + 1 == PT) begin m_mode = 6; m_won = 0; end
            end
            6: if (n) m_mode = 1;
            default: m_mode = 1;
        endcase
        // cycles spent in PAUSE so far, counted at each edge
        m_paused = (prev == 5) ? m_paused + 1 : 0;
    endtask

    task automatic tick(input bit n, input bit a, input bit u,
                        input bit d, input bit mi, input bit f);
        @(negedge clk);
        btn_next = n; btn_alt = a; btn_up = u; btn_down = d;
        miss = mi; fin_check = f;
        model_step(n, a, u, d, mi, f);
        @(posedge clk);
        #1;
        btn_next = 0; btn_alt = 0; btn_up = 0; btn_down = 0;
        miss = 0; fin_check = 0;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic press_next(input int k);
        for (int i = 0; i < k; i++) tick(1, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        @(negedge clk);
        #2 rst = 1;
        #1;
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL reset_mode got=%0d exp=1", mode); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (lives !== 4'd2) begin errors++; $display("FAIL reset_lives got=%0d exp=2", lives); end
        checks++; if (game_won !== 1'b0) begin errors++; $display("FAIL reset_won got=%0d exp=0", game_won); end
        checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL reset_run_en got=%0d exp=0", run_en); end
        @(negedge clk);
        rst = 0;
        model_reset();
    endtask

    task automatic test_happy();
        press_next(1);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL happy_edit got=%0d exp=2", mode); end
        press_next(1);
        checks++; if (mode !== 3'd3) begin errors++; $display("FAIL happy_diff got=%0d exp=3", mode); end
        press_next(1);
        checks++; if (mode !== 3'd4 || run_en !== 1'b1) begin errors++; $display("FAIL happy_run mode=%0d run_en=%0d exp=4/1", mode, run_en); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mode !== 3'd6 || game_won !== 1'b1 || run_en !== 1'b0) begin errors++; $display("FAIL happy_finish mode=%0d won=%0d run_en=%0d exp=6/1/0", mode, game_won, run_en); end
        tick(0, 0, 0, 0, 0, 1);
        checks++; if (mode !== 3'd6) begin errors++; $display("FAIL finish_hold got=%0d exp=6", mode); end
        press_next(1);
        checks++; if (mode !== 3'd1) begin errors++; $display("FAIL happy_idle got=%0d exp=1", mode); end
    endtask

    task automatic test_difficulty();
        press_next(2);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0, 0, 0);
        checks++; if (level !== 2'd2) begin errors++; $display("FAIL diff_up_sat got=%0d exp=2", level); end
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, 0, 0);
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL diff_down_sat got=%0d exp=0", level); end
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 1, 0, 0);
        checks++; if (level !== 2'd1) begin errors++; $display("FAIL diff_both got=%0d exp=1", level); end
        press_next(1);
        tick(0, 0, 1, 0, 0, 1);
        press_next(1);
        checks++; if (mode !== 3'd1 || level !== 2'd1) begin errors++; $display("FAIL diff_persist mode=%0d level=%0d exp=1/1", mode, level); end
    endtask

    task automatic test_lives();
        press_next(3);
        tick(0, 0, 0, 0, 1, 0);
        checks++; if (lives !== 4'd1 || mode !== 3'd4) begin errors++; $display("FAIL lives_first lives=%0d mode=%0d exp=1/4", lives, mode); end
        tick(0, 0, 0, 0, 1, 0);
        checks++; if (lives !== 4'd0 || mode !== 3'd6 || game_won !== 1'b0) begin errors++; $display("FAIL lives_last lives=%0d mode=%0d won=%0d exp=0/6/0", lives, mode, game_won); end
        press_next(4);
        checks++; if (lives !== 4'd2 || mode !== 3'd4) begin errors++; $display("FAIL lives_reload lives=%0d mode=%0d exp=2/4", lives, mode); end
        tick(0, 0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 1, 1);
        checks++; if (mode !== 3'd6 || game_won !== 1'b1) begin errors++; $display("FAIL lives_fin_wins mode=%0d won=%0d exp=6/1", mode, game_won); end
    endtask

    task automatic test_pause();
        press_next(4);
        tick(1, 0, 0, 0, 1, 0);
        checks++; if (mode !== 3'd5 || lives !== 4'd1) begin errors++; $display("FAIL pause_enter mode=%0d lives=%0d exp=5/1", mode, lives); end
        idle(PT - 1);
        checks++; if (mode !== 3'd5) begin errors++; $display("FAIL pause_early got=%0d exp=5", mode); end
        idle(1);
        checks++; if (mode !== 3'd6 || game_won !== 1'b0) begin errors++; $display("FAIL pause_timeout mode=%0d won=%0d exp=6/0", mode, game_won); end
        press_next(5);
        idle(2);
        press_next(1);
        checks++; if (mode !== 3'd4 || run_en !== 1'b1) begin errors++; $display("FAIL pause_resume mode=%0d run_en=%0d exp=4/1", mode, run_en); end
        press_next(1);
        tick(0, 1, 0, 0, 0, 0);
        checks++; if (mode !== 3'd6 || game_won !== 1'b0) begin errors++; $display("FAIL pause_quit mode=%0d won=%0d exp=6/0", mode, game_won); end
        press_next(1);
    endtask

    task automatic test_ignored();
        press_next(1);
        tick(0, 1, 0, 0, 0, 0);
        checks++; if (mode !== 3'd2) begin errors++; $display("FAIL alt_in_edit got=%0d exp=2", mode); end
        press_next(2);
        tick(0, 0, 0, 0, 1, 0);
        press_next(1);
        tick(0, 0, 0, 0, 1, 1);
        checks++; if (mode !== 3'd5 || lives !== 4'd1) begin errors++; $display("FAIL miss_in_pause mode=%0d lives=%0d exp=5/1", mode, lives); end
    endtask

    task automatic test_reset_mid_pause();
        press_next(2);
        idle(5);
        #3 rst = 1;
        #1;
        checks++; if (mode !== 3'd1 || lives !== 4'd2 || run_en !== 1'b0) begin errors++; $display("FAIL reset_mid_pause mode=%0d lives=%0d run_en=%0d exp=1/2/0", mode, lives, run_en); end
        checks++; if (level !== 2'd0) begin errors++; $display("FAIL reset_mid_level got=%0d exp=0", level); end
        @(negedge clk);
        rst = 0;
        model_reset();
        press_next(4);
        idle(PT - 1);
        checks++; if (mode !== 3'd5) begin errors++; $display("FAIL fresh_pause_early got=%0d exp=5", mode); end
        idle(1);
        checks++; if (mode !== 3'd6) begin errors++; $display("FAIL fresh_pause_timeout got=%0d exp=6", mode); end
    endtask

    task automatic test_random();
        bit n, a, u, d, mi, f;
        int slow;
        for (int i = 0; i < 1500; i++) begin
            slow = (i / 100) % 2;
            n  = (slow != 0) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) == 0);
            a  = ($urandom_range(0, 9) == 0);
            u  = ($urandom_range(0, 2) == 0);
            d  = ($urandom_range(0, 2) == 0);
            mi = ($urandom_range(0, 5) == 0);
            f  = ($urandom_range(0, 19) == 0);
            tick(n, a, u, d, mi, f);
            checks++;
            if (mode !== 3'(m_mode) || level !== 2'(m_level) || lives !== 4'(m_lives)
                || game_won !== 1'(m_won) || run_en !== (m_mode == 4)) begin
                errors++;
                $display("FAIL random_%0d mode=%0d level=%0d lives=%0d won=%0d run_en=%0d exp=%0d/%0d/%0d/%0d/%0d",
                         i, mode, level, lives, game_won, run_en,
                         m_mode, m_level, m_lives, m_won, (m_mode == 4));
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_happy();
        test_difficulty();
        test_lives();
        test_pause();
        test_ignored();
        test_reset_mid_pause();
        test_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
